// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects the next PC and runs the
// req/ack handshake with instruction memory, feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        fetch_stall_o
);

    typedef enum logic [0:0] {StFetch, StReady} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        redirect;
    logic [31:0] target;
    logic        adv;

    // Jump wins over a simultaneous taken branch.
    assign redirect = jump_i | branch_taken_i;
    assign target   = jump_i ? jump_target_i : branch_target_i;
    assign adv      = pc_write_i & ~stall_i;
    assign pc_o     = pc_q + 32'd4;

    // State registers, asynchronously reset low.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            buf_q         <= NOP_INSTR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_q         <= buf_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state logic: rule order inside FETCH encodes priority.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ack_i && pend_valid_q) begin
                    // Data belongs to the wrong-path fetch; drop it and go to the saved target.
                    pc_d         = pend_target_q;
                    pend_valid_d = 1'b0;
                end else if (imem_ack_i && redirect && !stall_i) begin
                    pc_d = target;
                end else if (imem_ack_i && adv) begin
                    pc_d = pc_q + 32'd4;
                end else if (imem_ack_i) begin
                    buf_d   = imem_data_i;
                    state_d = StReady;
                end else if (redirect && !stall_i) begin
                    // Request address must stay stable, so remember the redirect until ack.
                    pend_valid_d  = 1'b1;
                    pend_target_d = target;
                end
            end
            StReady: begin
                if (redirect && !stall_i) begin
                    pc_d    = target;
                    state_d = StFetch;
                end else if (adv) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Outputs: forward memory data straight through when it is usable this cycle.
    always_comb begin
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_q;
        instr_o       = NOP_INSTR;
        fetch_stall_o = 1'b1;
        unique case (state_q)
            StFetch: begin
                imem_req_o = 1'b1;
                if (imem_ack_i && !pend_valid_q) begin
                    instr_o       = imem_data_i;
                    fetch_stall_o = 1'b0;
                end
            end
            StReady: begin
                instr_o       = buf_q;
                fetch_stall_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for the instruction-fetch stage.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_write_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        fetch_stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .fetch_stall_o   (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are then changed there.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; pc_write_i = 1'b1; stall_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = '0;
        jump_i = 1'b0; jump_target_i = '0;
        imem_ack_i = 1'b0; imem_data_i = '0;
        #2;
        chk("rst_req",   {31'b0, imem_req_o},    32'd1);
        chk("rst_addr",  imem_addr_o,            32'h0);
        chk("rst_instr", instr_o,                32'h0);
        chk("rst_stall", {31'b0, fetch_stall_o}, 32'd1);
        chk("rst_pc_o",  pc_o,                   32'h4);

        // Zero-wait memory: one fetch per cycle.
        #10; rst_i = 1'b1;
        imem_ack_i = 1'b1; imem_data_i = 32'hA000_0000; #1;
        chk("seq0_addr",  imem_addr_o,            32'h0);
        chk("seq0_pc_o",  pc_o,                   32'h4);
        chk("seq0_instr", instr_o,                32'hA000_0000);
        chk("seq0_stall", {31'b0, fetch_stall_o}, 32'd0);
        tick(); imem_data_i = 32'hA000_0004; #1;
        chk("seq1_addr",  imem_addr_o,            32'h4);
        chk("seq1_pc_o",  pc_o,                   32'h8);
        chk("seq1_instr", instr_o,                32'hA000_0004);

        // Ack delayed three cycles at pc=8.
        for (int i = 0; i < 3; i++) begin
            tick(); imem_ack_i = 1'b0; #1;
            chk("wait_addr",  imem_addr_o,            32'h8);
            chk("wait_req",   {31'b0, imem_req_o},    32'd1);
            chk("wait_stall", {31'b0, fetch_stall_o}, 32'd1);
            chk("wait_instr", instr_o,                32'h0);
        end
        tick(); imem_ack_i = 1'b1; imem_data_i = 32'h8C22_0004; #1;
        chk("ack_instr", instr_o,                32'h8C22_0004);
        chk("ack_stall", {31'b0, fetch_stall_o}, 32'd0);
        chk("ack_addr",  imem_addr_o,            32'h8);
        tick(); imem_data_i = 32'hA000_000C; #1;
        chk("seq3_addr", imem_addr_o, 32'hC);
        chk("seq3_pc_o", pc_o,        32'h10);

        // Hazard hold at pc=16: instruction parks in the buffer.
        tick(); imem_data_i = 32'hA000_0010; pc_write_i = 1'b0; #1;
        chk("hold_fwd", instr_o, 32'hA000_0010);
        tick(); imem_ack_i = 1'b0; imem_data_i = 32'hFFFF_FFFF; #1;
        chk("hold1_req",   {31'b0, imem_req_o},    32'd0);
        chk("hold1_instr", instr_o,                32'hA000_0010);
        chk("hold1_addr",  imem_addr_o,            32'h10);
        chk("hold1_stall", {31'b0, fetch_stall_o}, 32'd0);
        tick(); pc_write_i = 1'b1; #1;
        chk("hold2_req",   {31'b0, imem_req_o}, 32'd0);
        chk("hold2_instr", instr_o,             32'hA000_0010);
        tick(); #1;
        chk("adv_addr", imem_addr_o,         32'h14);
        chk("adv_req",  {31'b0, imem_req_o}, 32'd1);

        // Branch from READY at pc=20.
        imem_ack_i = 1'b1; imem_data_i = 32'hA000_0014; pc_write_i = 1'b0;
        tick(); imem_ack_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h40; #1;
        chk("br_ready_instr", instr_o, 32'hA000_0014);
        tick(); branch_taken_i = 1'b0; #1;
        chk("br_addr",  imem_addr_o,            32'h40);
        chk("br_stall", {31'b0, fetch_stall_o}, 32'd1);

        // Jump beats a simultaneous branch.
        imem_ack_i = 1'b1; imem_data_i = 32'hA000_0040;
        tick(); imem_ack_i = 1'b0; branch_taken_i = 1'b1; jump_i = 1'b1;
        jump_target_i = 32'h80; #1;
        tick(); branch_taken_i = 1'b0; jump_i = 1'b0; pc_write_i = 1'b1; #1;
        chk("jmp_addr", imem_addr_o, 32'h80);

        // Redirect while a request is outstanding.
        imem_ack_i = 1'b1; imem_data_i = 32'hA000_0080;
        tick(); imem_ack_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h100; #1;
        chk("pend_addr", imem_addr_o, 32'h84);
        tick(); branch_taken_i = 1'b0; imem_ack_i = 1'b1; imem_data_i = 32'hDEAD_BEEF; #1;
        chk("pend_hold_addr", imem_addr_o,            32'h84);
        chk("pend_drop",      instr_o,                32'h0);
        chk("pend_stall",     {31'b0, fetch_stall_o}, 32'd1);
        tick(); imem_ack_i = 1'b0; #1;
        chk("pend_target", imem_addr_o, 32'h100);

        // Data-memory stall blocks a redirect; outstanding ack still lands.
        stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h200;
        tick(); #1;
        chk("stall_addr", imem_addr_o, 32'h100);
        imem_ack_i = 1'b1; imem_data_i = 32'h1234_5678; #1;
        chk("stall_fwd", instr_o, 32'h1234_5678);
        tick(); imem_ack_i = 1'b0; #1;
        chk("stall_ready_req",   {31'b0, imem_req_o}, 32'd0);
        chk("stall_ready_instr", instr_o,             32'h1234_5678);
        tick(); #1;
        chk("stall_hold_addr", imem_addr_o, 32'h100);
        stall_i = 1'b0; branch_taken_i = 1'b0;
        tick(); #1;
        chk("unstall_addr", imem_addr_o, 32'h104);

        // Asynchronous reset in the middle of a request.
        #2; rst_i = 1'b0; #1;
        chk("arst_addr",  imem_addr_o,            32'h0);
        chk("arst_stall", {31'b0, fetch_stall_o}, 32'd1);
        chk("arst_pc_o",  pc_o,                   32'h4);
        #1; rst_i = 1'b1;

        // PC+4 wraps at the top of the address space.
        imem_ack_i = 1'b1; imem_data_i = 32'hA000_0000; jump_i = 1'b1;
        jump_target_i = 32'hFFFF_FFFC;
        tick(); jump_i = 1'b0; #1;
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_pc_o", pc_o,        32'h0);
        tick(); #1;
        chk("wrap_next", imem_addr_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
